// File: rtl/xbar_slave_arb.sv
`default_nettype none
// ============================================================================
// Module      : xbar_slave_arb
// Description : Arbiter and read-response router for one crossbar slave port.
//               NUM_MASTERS requesters compete for a single registered request
//               stage. The master ID of each forwarded read is queued in an
//               in-order ID FIFO, so each slave read response can be steered
//               back to the master that issued it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_MASTERS    : number of requesting masters (2..16)
//   ID_DEPTH       : outstanding reads held by the ID FIFO (power of two, >=2)
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-low reset
//   master_req_i   : per-master request valid
//   master_data_bi : request words, master k at [67k+66:67k], bit 66 = we
//   master_ack_o   : per-master accept (combinational, one-hot or zero)
//   master_resp_o  : per-master read-response strobe (registered, one-hot)
//   master_rdata_bo: read data shared by all masters, valid with master_resp_o
//   slave_req_o    : registered request valid toward the slave
//   slave_data_bo  : registered request word
//   slave_ack_i    : slave accepts slave_data_bo
//   slave_resp_i   : slave read-response strobe, in request order
//   slave_rdata_bi : slave read data
//   err_o          : sticky, response received with the ID FIFO empty
// Build option
//   XBAR_ARB_FIXED_PRIO_EN : when defined, lowest-index eligible master wins
//                            and no round-robin pointer is kept.
// ============================================================================
module xbar_slave_arb #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_MASTERS-1:0]   master_req_i,
    input  logic [67*NUM_MASTERS-1:0] master_data_bi,
    output logic [NUM_MASTERS-1:0]   master_ack_o,
    output logic [NUM_MASTERS-1:0]   master_resp_o,
    output logic [31:0]              master_rdata_bo,
    output logic                     slave_req_o,
    output logic [66:0]              slave_data_bo,
    input  logic                     slave_ack_i,
    input  logic                     slave_resp_i,
    input  logic [31:0]              slave_rdata_bi,
    output logic                     err_o
);

    localparam int c_W      = 67;
    localparam int c_WE_BIT = 66;
    localparam int c_IDW    = $clog2(NUM_MASTERS);
    localparam int c_PW     = $clog2(ID_DEPTH);
    localparam logic [c_PW:0]          c_FULL = (c_PW+1)'(ID_DEPTH);
    localparam logic [NUM_MASTERS-1:0] c_ONE  = (NUM_MASTERS)'(1);

    // Request stage
    logic                   r_slave_req;
    logic [c_W-1:0]         r_slave_data;

    // ID FIFO
    logic [c_IDW-1:0]       r_id_mem [ID_DEPTH];
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_PW:0]          r_count;

    // Response stage
    logic [NUM_MASTERS-1:0] r_resp;
    logic [31:0]            r_rdata;
    logic                   r_err;

`ifndef XBAR_ARB_FIXED_PRIO_EN
    logic [c_IDW-1:0]       r_rr_ptr;
`endif

    logic                   w_ready;
    logic                   w_full;
    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_found;
    logic [c_IDW-1:0]       w_win;
    int                     w_scan;
    logic [c_W-1:0]         w_win_data;
    logic                   w_grant;
    logic                   w_push;
    logic                   w_pop;
    logic [NUM_MASTERS-1:0] w_ack;
    logic [c_IDW-1:0]       w_head;

    // The output register may be refilled when it is empty or being consumed.
    assign w_ready = ~r_slave_req | slave_ack_i;
    // Registered count, so a same-cycle pop never frees a slot for a read.
    assign w_full  = (r_count == c_FULL);

    // Writes never need an ID slot; reads only when the FIFO has room.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_elig[k] = master_req_i[k] &
                        (master_data_bi[c_W*k + c_WE_BIT] | ~w_full);
        end
    end

    // First eligible master in scan order wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef XBAR_ARB_FIXED_PRIO_EN
            w_scan = i;
`else
            w_scan = (int'(r_rr_ptr) + 1 + i) % NUM_MASTERS;
`endif
            if (!w_found && w_elig[w_scan]) begin
                w_found = 1'b1;
                w_win   = c_IDW'(w_scan);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        w_ack      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_win == c_IDW'(k)) begin
                w_win_data = master_data_bi[c_W*k +: c_W];
            end
            w_ack[k] = w_grant && (w_win == c_IDW'(k));
        end
    end

    assign w_grant = w_ready & w_found;
    assign w_push  = w_grant & ~w_win_data[c_WE_BIT];
    assign w_pop   = slave_resp_i & (r_count != '0);
    assign w_head  = r_id_mem[r_rd_ptr];

    // Request register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_slave_req  <= 1'b0;
            r_slave_data <= '0;
        end else if (w_ready) begin
            r_slave_req <= w_found;
            if (w_found) begin
                r_slave_data <= w_win_data;
            end
        end
    end

`ifndef XBAR_ARB_FIXED_PRIO_EN
    // Reset to the last master so master 0 is scanned first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr_ptr <= c_IDW'(NUM_MASTERS - 1);
        end else if (w_grant) begin
            r_rr_ptr <= w_win;
        end
    end
`endif

    // ID storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= w_win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Response routing; the strobe lasts exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_resp  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_resp <= '0;
            if (w_pop) begin
                r_resp  <= c_ONE << w_head;
                r_rdata <= slave_rdata_bi;
            end
            if (slave_resp_i && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign master_ack_o    = w_ack;
    assign master_resp_o   = r_resp;
    assign master_rdata_bo = r_rdata;
    assign slave_req_o     = r_slave_req;
    assign slave_data_bo   = r_slave_data;
    assign err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xbar_slave_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_slave_arb
// Description : Randomized self-checking bench for xbar_slave_arb, compared
//               against a transaction-level model (winner scan, ID queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_slave_arb;

    localparam int N = 4;
    localparam int D = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      master_req_i;
    logic [67*N-1:0]   master_data_bi;
    logic [N-1:0]      master_ack_o;
    logic [N-1:0]      master_resp_o;
    logic [31:0]       master_rdata_bo;
    logic              slave_req_o;
    logic [66:0]       slave_data_bo;
    logic              slave_ack_i;
    logic              slave_resp_i;
    logic [31:0]       slave_rdata_bi;
    logic              err_o;

    xbar_slave_arb #(.NUM_MASTERS(N), .ID_DEPTH(D)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .master_req_i   (master_req_i),
        .master_data_bi (master_data_bi),
        .master_ack_o   (master_ack_o),
        .master_resp_o  (master_resp_o),
        .master_rdata_bo(master_rdata_bo),
        .slave_req_o    (slave_req_o),
        .slave_data_bo  (slave_data_bo),
        .slave_ack_i    (slave_ack_i),
        .slave_resp_i   (slave_resp_i),
        .slave_rdata_bi (slave_rdata_bi),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act,
                            input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_sreq;
    logic [66:0] m_sdata;
    logic [N-1:0] m_resp;
    logic [31:0] m_rdata;
    bit          m_err;
    int          m_last;
    int          m_ids[$];

    task automatic model_reset();
        m_sreq  = 1'b0;
        m_sdata = '0;
        m_resp  = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_last  = N - 1;
        m_ids.delete();
    endtask

    task automatic check_regs();
        check_eq("slave_req", 128'(slave_req_o), 128'(m_sreq));
        check_eq("slave_data", 128'(slave_data_bo), 128'(m_sdata));
        check_eq("master_resp", 128'(master_resp_o), 128'(m_resp));
        if (m_resp != '0) begin
            check_eq("master_rdata", 128'(master_rdata_bo), 128'(m_rdata));
        end
        check_eq("err", 128'(err_o), 128'(m_err));
    endtask

    // One clock of random stimulus; percentages select request, write,
    // slave-accept and slave-response probabilities.
    task automatic cycle(input int p_req, input int p_we, input int p_sack,
                         input int p_resp);
        logic [66:0]  word;
        logic [N-1:0] exp_ack;
        bit           ready;
        int           win;
        int           k;
        int           h;
        @(negedge clk);
        for (int m = 0; m < N; m++) begin
            master_req_i[m] = ($urandom_range(99) < p_req);
            word = {3'($urandom), $urandom, $urandom};
            word[66] = ($urandom_range(99) < p_we);
            master_data_bi[67*m +: 67] = word;
        end
        slave_ack_i    = ($urandom_range(99) < p_sack);
        slave_resp_i   = ($urandom_range(99) < p_resp);
        slave_rdata_bi = $urandom;
        #1;
        check_regs();

        ready = !m_sreq || slave_ack_i;
        win   = -1;
        if (ready) begin
            for (int i = 1; i <= N; i++) begin
`ifdef XBAR_ARB_FIXED_PRIO_EN
                k = i - 1;
`else
                k = (m_last + i) % N;
`endif
                if (win < 0 && master_req_i[k] &&
                    (master_data_bi[67*k+66] || m_ids.size() < D)) begin
                    win = k;
                end
            end
        end
        exp_ack = '0;
        if (win >= 0) exp_ack[win] = 1'b1;
        check_eq("master_ack", 128'(master_ack_o), 128'(exp_ack));

        // Next-state: pop before push, both seen on the same edge.
        m_resp = '0;
        if (slave_resp_i) begin
            if (m_ids.size() > 0) begin
                h = m_ids.pop_front();
                m_resp[h] = 1'b1;
                m_rdata = slave_rdata_bi;
            end else begin
                m_err = 1'b1;
            end
        end
        if (ready) begin
            if (win >= 0) begin
                m_sreq  = 1'b1;
                m_sdata = master_data_bi[67*win +: 67];
                m_last  = win;
                if (!master_data_bi[67*win+66]) m_ids.push_back(win);
            end else begin
                m_sreq = 1'b0;
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset();
        @(negedge clk);
        master_req_i = '0;
        slave_resp_i = 1'b0;
        slave_ack_i  = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_eq("rst_rdata", 128'(master_rdata_bo), 128'd0);
        check_eq("rst_ack", 128'(master_ack_o), 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i          = 1'b0;
        master_req_i   = '0;
        master_data_bi = '0;
        slave_ack_i    = 1'b0;
        slave_resp_i   = 1'b0;
        slave_rdata_bi = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_regs();
        check_eq("rst_rdata", 128'(master_rdata_bo), 128'd0);
        rst_i = 1'b1;

        repeat (20)  cycle(100, 100, 100, 0);   // all writes, rotating grants
        repeat (30)  cycle(100, 0, 40, 0);      // reads with stalls, FIFO fills
        repeat (200) cycle(60, 20, 70, 10);
        repeat (200) cycle(50, 40, 60, 40);
        repeat (100) cycle(20, 50, 50, 70);     // drain, empty-FIFO responses
        repeat (10)  cycle(100, 0, 100, 0);     // reads outstanding
        mid_reset();
        repeat (200) cycle(70, 30, 60, 25);
        repeat (40)  cycle(100, 0, 100, 50);    // push and pop together
        mid_reset();
        repeat (200) cycle(80, 50, 50, 30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
